// File: rtl/instr_prefetch_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch_buffer_if
// Purpose  : Core-side handshake and RAM port A signals of the instruction
//            prefetch buffer, bundled with master (buffer) and slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_prefetch_buffer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    logic                  req_i;
    logic                  branch_i;
    logic [ADDR_WIDTH-1:0] branch_addr_i;
    logic                  instr_valid_o;
    logic                  instr_ready_i;
    logic [31:0]           instr_rdata_o;
    logic [ADDR_WIDTH-1:0] instr_addr_o;
    logic                  en_a_o;
    logic [ADDR_WIDTH-1:0] addr_a_o;
    logic [LINE_WIDTH-1:0] rdata_a_i;

    // Prefetch buffer side
    modport master (
        input  req_i, branch_i, branch_addr_i, instr_ready_i, rdata_a_i,
        output instr_valid_o, instr_rdata_o, instr_addr_o, en_a_o, addr_a_o
    );

    // Core / RAM side
    modport slave (
        output req_i, branch_i, branch_addr_i, instr_ready_i, rdata_a_i,
        input  instr_valid_o, instr_rdata_o, instr_addr_o, en_a_o, addr_a_o
    );
endinterface
`default_nettype wire

// File: rtl/instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch_buffer
// Purpose  : Fetches LINE_WIDTH-bit lines from RAM port A and serves them to
//            the core one 32-bit word at a time; flushes on branch redirect.
// Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch_buffer #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    LINE_WIDTH = 128,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
    input wire clk_i,
    input wire rst_i,
    instr_prefetch_buffer_if.master bus
);
    localparam int WORDS = LINE_WIDTH / 32;
    localparam int PTR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(4 * WORDS);
    localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(WORDS);

    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [ADDR_WIDTH-1:0] line_base_next;
    logic [31:0]           line_buf [WORDS];
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  pending;

    logic                  handshake;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] issue_addr;

    // Request decision: a branch always issues; otherwise refill only once the
    // buffer is empty or its last word is leaving, and never over a pending line.
    always_comb begin
        handshake  = (count != '0) && bus.instr_ready_i;
        issue_addr = bus.branch_i ? {bus.branch_addr_i[ADDR_WIDTH-1:2], 2'b00} : fetch_addr;
        issue      = bus.branch_i ||
                     (bus.req_i && !pending &&
                      ((count == '0) || ((count == CNT_W'(1)) && handshake)));
    end

    // Reset is folded in so the port stays quiet the instant reset asserts.
    assign bus.en_a_o   = issue && !rst_i;
    assign bus.addr_a_o = rst_i ? BOOT_ADDR : issue_addr;

    // Core-facing outputs come only from registered state.
    assign bus.instr_valid_o = (count != '0);
    assign bus.instr_rdata_o = line_buf[rd_ptr];
    assign bus.instr_addr_o  = line_base + ADDR_WIDTH'({rd_ptr, 2'b00});

    // Line tracking, capture and consumption; branch overrides capture and handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_addr     <= BOOT_ADDR;
            line_base      <= BOOT_ADDR;
            line_base_next <= BOOT_ADDR;
            rd_ptr         <= '0;
            count          <= '0;
            pending        <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                line_buf[i] <= '0;
            end
        end else begin
            pending <= issue;
            if (issue) begin
                line_base_next <= issue_addr;
                fetch_addr     <= issue_addr + LINE_BYTES;
            end

            if (bus.branch_i) begin
                count <= '0;
            end else if (pending) begin
                for (int i = 0; i < WORDS; i++) begin
                    line_buf[i] <= bus.rdata_a_i[32*i +: 32];
                end
                count     <= FULL_COUNT;
                rd_ptr    <= '0;
                line_base <= line_base_next;
            end else if (handshake) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                count  <= count - CNT_W'(1);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_prefetch_buffer
// Purpose  : Self-checking bench for instr_prefetch_buffer: directed scenarios
//            plus randomized traffic against an instruction-stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_buffer;
    localparam int AW    = 16;
    localparam int AW8   = 8;
    localparam int LW    = 128;
    localparam int WORDS = LW / 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_prefetch_buffer_if #(.ADDR_WIDTH(AW),  .LINE_WIDTH(LW)) bus  ();
    instr_prefetch_buffer_if #(.ADDR_WIDTH(AW8), .LINE_WIDTH(LW)) bus8 ();

    instr_prefetch_buffer #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .BOOT_ADDR(16'h0000)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    instr_prefetch_buffer #(.ADDR_WIDTH(AW8), .LINE_WIDTH(LW), .BOOT_ADDR(8'h00)) u_dut8 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus8.master)
    );

    logic [31:0] mem  [0:16383];
    logic [31:0] mem8 [0:63];

    // RAM models: line for the address of cycle n appears in cycle n+1
    always @(posedge clk) begin
        for (int i = 0; i < WORDS; i++) begin
            bus.rdata_a_i[32*i +: 32]  <= mem[bus.addr_a_o[15:2] + 14'(i)];
            bus8.rdata_a_i[32*i +: 32] <= mem8[bus8.addr_a_o[7:2] + 6'(i)];
        end
    end

    int tests = 0;
    int fails = 0;

    // Stream model state
    logic [15:0] exp_addr;
    logic [15:0] last_target;
    int          since;
    bit          hold;
    logic [15:0] hold_addr;
    logic [31:0] hold_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        exp_addr    = 16'h0000;
        last_target = 16'h0000;
        since       = 0;
        hold        = 1'b0;
    endtask

    // Checks this cycle's outputs against the stream rules, updates the
    // model, then moves to the next sampling point.
    task automatic advance();
        logic        hs;
        logic [15:0] tgt;
        tgt = {bus.branch_addr_i[15:2], 2'b00};
        hs  = bus.instr_valid_o && bus.instr_ready_i && !bus.branch_i;
        if (hold) begin
            chk("hold_valid", 32'(bus.instr_valid_o), 32'd1);
            chk("hold_addr",  32'(bus.instr_addr_o), 32'(hold_addr));
            chk("hold_data",  bus.instr_rdata_o, hold_data);
        end
        if (since == 1) chk("capture_valid", 32'(bus.instr_valid_o), 32'd0);
        if (since == 2) begin
            chk("redirect_valid", 32'(bus.instr_valid_o), 32'd1);
            chk("redirect_addr",  32'(bus.instr_addr_o), 32'(last_target));
        end
        if (bus.branch_i) begin
            chk("branch_en",   32'(bus.en_a_o), 32'd1);
            chk("branch_addr", 32'(bus.addr_a_o), 32'(tgt));
        end else if (!bus.req_i) begin
            chk("noreq_en", 32'(bus.en_a_o), 32'd0);
        end
        if (hs) begin
            chk("stream_addr", 32'(bus.instr_addr_o), 32'(exp_addr));
            chk("stream_data", bus.instr_rdata_o, mem[exp_addr[15:2]]);
            exp_addr = exp_addr + 16'd4;
        end
        hold      = bus.instr_valid_o && !bus.instr_ready_i && !bus.branch_i;
        hold_addr = bus.instr_addr_o;
        hold_data = bus.instr_rdata_o;
        if (bus.branch_i) begin
            exp_addr    = tgt;
            last_target = tgt;
            since       = 1;
        end else if (since < 3) begin
            since++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] boot_valid;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        for (int i = 0; i < 16; i++)    mem[i] = 32'h11 * (i + 1);
        for (int i = 0; i < 64; i++)    mem8[i] = $urandom;
        bus.req_i = 1'b0;  bus.branch_i = 1'b0;  bus.branch_addr_i = '0;  bus.instr_ready_i = 1'b1;
        bus8.req_i = 1'b0; bus8.branch_i = 1'b0; bus8.branch_addr_i = '0; bus8.instr_ready_i = 1'b1;
        model_reset();
        since = 3;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
        chk("rst_en",    32'(bus.en_a_o), 32'd0);
        chk("rst_addr_a", 32'(bus.addr_a_o), 32'h0);
        chk("rst_rdata", bus.instr_rdata_o, 32'h0);
        chk("rst_iaddr", 32'(bus.instr_addr_o), 32'h0);
        @(negedge clk);

        // Boot: fetch from 0, first word two cycles later, bubble after each line
        rst = 1'b0;
        bus.req_i = 1'b1;
        model_reset();
        boot_valid = 8'b1011_1100;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("boot_valid", 32'(bus.instr_valid_o), 32'(boot_valid[c]));
            if (c == 0) begin
                chk("boot_en",   32'(bus.en_a_o), 32'd1);
                chk("boot_addr", 32'(bus.addr_a_o), 32'h0);
            end
            if (c == 2) chk("boot_first", bus.instr_rdata_o, 32'h11);
            if (c == 5) chk("boot_refill", 32'(bus.addr_a_o), 32'h10);
            if (c == 7) chk("boot_second_line", bus.instr_rdata_o, 32'h55);
            advance();
        end

        // Backpressure on the word at 0x8
        bus.branch_i = 1'b1; bus.branch_addr_i = 16'h0000;
        #1; advance();
        bus.branch_i = 1'b0;
        repeat (3) begin #1; advance(); end
        bus.instr_ready_i = 1'b0;
        repeat (5) begin
            #1;
            chk("bp_addr", 32'(bus.instr_addr_o), 32'h8);
            chk("bp_en",   32'(bus.en_a_o), 32'd0);
            advance();
        end
        bus.instr_ready_i = 1'b1;
        repeat (6) begin #1; advance(); end

        // Branch mid-line while 0x4 is presented
        bus.branch_i = 1'b1; bus.branch_addr_i = 16'h0000;
        #1; advance();
        bus.branch_i = 1'b0;
        repeat (2) begin #1; advance(); end
        #1;
        chk("mid_pre_addr", 32'(bus.instr_addr_o), 32'h4);
        bus.branch_i = 1'b1; bus.branch_addr_i = 16'h0106;
        #1;
        chk("mid_addr_a", 32'(bus.addr_a_o), 32'h0104);
        advance();
        bus.branch_i = 1'b0;
        #1; advance();
        #1;
        chk("mid_tgt_addr", 32'(bus.instr_addr_o), 32'h0104);
        advance();
        #1;
        chk("mid_next_addr", 32'(bus.instr_addr_o), 32'h0108);
        advance();

        // Branch in the capture cycle discards the old line
        bus.branch_i = 1'b1; bus.branch_addr_i = 16'h0000;
        #1; advance();
        bus.branch_addr_i = 16'h0200;
        #1; advance();
        bus.branch_i = 1'b0;
        #1;
        chk("pend_gap", 32'(bus.instr_valid_o), 32'd0);
        advance();
        #1;
        chk("pend_valid", 32'(bus.instr_valid_o), 32'd1);
        chk("pend_addr",  32'(bus.instr_addr_o), 32'h0200);
        chk("pend_data",  bus.instr_rdata_o, mem[16'h0200 >> 2]);
        advance();

        // Address wrap on the 8-bit instance
        bus8.branch_i = 1'b1; bus8.branch_addr_i = 8'hF0;
        #1;
        chk("wrap_first_addr", 32'(bus8.addr_a_o), 32'hF0);
        advance();
        bus8.branch_i = 1'b0; bus8.req_i = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            #1;
            if (c == 2) begin
                chk("wrap_f0_addr", 32'(bus8.instr_addr_o), 32'hF0);
                chk("wrap_f0_data", bus8.instr_rdata_o, mem8[60]);
            end
            if (c == 5) begin
                chk("wrap_en",   32'(bus8.en_a_o), 32'd1);
                chk("wrap_addr", 32'(bus8.addr_a_o), 32'h00);
            end
            if (c == 7) begin
                chk("wrap_00_addr", 32'(bus8.instr_addr_o), 32'h00);
                chk("wrap_00_data", bus8.instr_rdata_o, mem8[0]);
            end
            advance();
        end
        bus8.req_i = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bus.req_i         = ($urandom_range(0, 7) != 0);
            bus.instr_ready_i = ($urandom_range(0, 3) != 0);
            bus.branch_i      = ($urandom_range(0, 19) == 0);
            bus.branch_addr_i = 16'($urandom);
            #1; advance();
        end

        // Asynchronous reset in mid-stream
        bus.req_i = 1'b1; bus.instr_ready_i = 1'b1; bus.branch_i = 1'b0;
        repeat (4) begin #1; advance(); end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.instr_valid_o), 32'd0);
        chk("arst_en",    32'(bus.en_a_o), 32'd0);
        chk("arst_iaddr", 32'(bus.instr_addr_o), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("restart_en",   32'(bus.en_a_o), 32'd1);
        chk("restart_addr", 32'(bus.addr_a_o), 32'h0);
        repeat (8) begin #1; advance(); end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
